// File: rtl/display_pkg.sv
// Shared types and constants for the display value encoder: FSM states,
// seven-segment patterns (bit 6 = a ... bit 0 = g, active-high) and the BCD step helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ENCODE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;

  // Entry n is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  localparam int BCD_W = 12;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to seven-segment pattern; non-decimal nibbles are blank.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_DIGITS[0];
      4'd1: seg = SEG_DIGITS[1];
      4'd2: seg = SEG_DIGITS[2];
      4'd3: seg = SEG_DIGITS[3];
      4'd4: seg = SEG_DIGITS[4];
      4'd5: seg = SEG_DIGITS[5];
      4'd6: seg = SEG_DIGITS[6];
      4'd7: seg = SEG_DIGITS[7];
      4'd8: seg = SEG_DIGITS[8];
      4'd9: seg = SEG_DIGITS[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_value_encoder.sv
// Converts a byte (optionally two's complement) into sign/hundreds/tens/units
// segment patterns using an 8-step double-dabble, then a single encode cycle.
module display_value_encoder
  import display_pkg::*;
#(
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic [6:0] b1,
  output logic [6:0] b2,
  output logic [6:0] b3,
  output logic [6:0] b4,
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state
);

  // Handshake: load is a level request sampled only while idle (busy=0);
  // busy rises on the accepting edge and done pulses for one cycle when
  // b1..b4 take new values. Requests seen while busy are dropped, not queued.

  state_t           state;
  logic [7:0]       bin;
  logic [BCD_W-1:0] bcd;
  logic [2:0]       step;
  logic             neg;

  logic [7:0]       mag;
  logic [BCD_W-1:0] adj;
  logic [6:0]       seg_h;
  logic [6:0]       seg_t;
  logic [6:0]       seg_u;
  logic             hund_zero;
  logic             tens_zero;
  logic [6:0]       next_b2;
  logic [6:0]       next_b3;

  // Negating 8'h80 wraps back to 8'h80, which read as unsigned is 128.
  assign mag = (signed_mode && value[7]) ? (~value + 8'd1) : value;
  assign adj = dabble_adjust(bcd);

  seg7_encode u_hund (.bcd(bcd[11:8]), .seg(seg_h));
  seg7_encode u_tens (.bcd(bcd[7:4]),  .seg(seg_t));
  seg7_encode u_unit (.bcd(bcd[3:0]),  .seg(seg_u));

  assign hund_zero = (bcd[11:8] == 4'd0);
  assign tens_zero = (bcd[7:4] == 4'd0);
  assign next_b2   = ((BLANK_LEADING != 0) && hund_zero) ? SEG_BLANK : seg_h;
  assign next_b3   = ((BLANK_LEADING != 0) && hund_zero && tens_zero) ? SEG_BLANK : seg_t;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      bin   <= 8'd0;
      bcd   <= '0;
      step  <= 3'd0;
      neg   <= 1'b0;
      b1    <= SEG_BLANK;
      b2    <= SEG_BLANK;
      b3    <= SEG_BLANK;
      b4    <= SEG_BLANK;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin   <= mag;
            bcd   <= '0;
            step  <= 3'd0;
            neg   <= signed_mode & value[7];
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd  <= {adj[BCD_W-2:0], bin[7]};
          bin  <= {bin[6:0], 1'b0};
          step <= step + 3'd1;
          if (step == 3'd7) begin
            state <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          b1    <= neg ? SEG_MINUS : SEG_BLANK;
          b2    <= next_b2;
          b3    <= next_b3;
          b4    <= seg_u;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
